// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 asynchronous serial receiver for a 50 MHz system clock.
//            Selectable baud rate (9600..115200). The divisor table matches
//            the companion transmitter. Each bit is sampled three times
//            around mid-bit and resolved by majority vote. One-cycle strobes
//            flag good bytes (rx_done) and bad stop bits (frame_err).
// Revision : 1.0  initial release
// ============================================================================
module uart_rx (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic [2:0] baud_set,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    // Bit-period divisors (period = divisor + 1 clocks at 50 MHz)
    localparam logic [15:0] c_DIV_9600   = 16'd5207;
    localparam logic [15:0] c_DIV_19200  = 16'd2603;
    localparam logic [15:0] c_DIV_38400  = 16'd1301;
    localparam logic [15:0] c_DIV_57600  = 16'd867;
    localparam logic [15:0] c_DIV_115200 = 16'd433;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_p;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [15:0] r_div_q;
    logic [1:0]  r_samp;
    logic [7:0]  r_rx_data;
    logic        r_rx_done;
    logic        r_frame_err;

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_shift_nxt;
    logic [15:0] w_div_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_done_nxt;
    logic        w_ferr_nxt;

    logic [15:0] w_bps_dr;
    logic [15:0] w_half;
    logic        w_fall;
    logic        w_at_s0;
    logic        w_at_s1;
    logic        w_at_res;
    logic        w_at_end;
    logic        w_vote;

    // Divisor lookup; unused encodings fall back to 9600 baud
    always_comb begin
        w_bps_dr = c_DIV_9600;
        case (baud_set)
            3'd0:    w_bps_dr = c_DIV_9600;
            3'd1:    w_bps_dr = c_DIV_19200;
            3'd2:    w_bps_dr = c_DIV_38400;
            3'd3:    w_bps_dr = c_DIV_57600;
            3'd4:    w_bps_dr = c_DIV_115200;
            default: w_bps_dr = c_DIV_9600;
        endcase
    end

    // Mid-bit point and the three-sample window around it. The window is
    // derived from the latched divisor so a baud change mid-frame cannot
    // disturb the frame in progress.
    assign w_half   = r_div_q >> 1;
    assign w_at_s0  = (r_cnt == (w_half - 16'd1));
    assign w_at_s1  = (r_cnt == w_half);
    assign w_at_res = (r_cnt == (w_half + 16'd1));
    assign w_at_end = (r_cnt == r_div_q);

    // Start bit is a 1->0 transition seen on the synchronized line; a line
    // that is still low after a framing error does not qualify.
    assign w_fall = r_rx_p & ~r_rx_s;

    // Majority of the samples taken at H-1, H and the live sample at H+1
    assign w_vote = (r_samp[0] & r_samp[1]) |
                    (r_samp[0] & r_rx_s)    |
                    (r_samp[1] & r_rx_s);

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_p  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rx_s  <= r_sync1;
            r_rx_p  <= r_rx_s;
        end
    end

    // Capture the first two of the three mid-bit samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp <= 2'b00;
        end else begin
            if (w_at_s0) begin
                r_samp[0] <= r_rx_s;
            end
            if (w_at_s1) begin
                r_samp[1] <= r_rx_s;
            end
        end
    end

    // Next-state, counter, shift-register and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_div_nxt   = r_div_q;
        w_data_nxt  = r_rx_data;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 16'd0;
                w_idx_nxt = 3'd0;
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_div_nxt   = w_bps_dr;
                end
            end

            ST_START: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_at_res && w_vote) begin
                    // Line went back high before mid start bit: noise
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else if (w_at_end) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = 3'd0;
                end
            end

            ST_DATA: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_at_res) begin
                    w_shift_nxt[r_idx] = w_vote;
                end
                if (w_at_end) begin
                    w_cnt_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                w_cnt_nxt = r_cnt + 16'd1;
                // Leave at mid stop bit so a following start bit from a
                // slightly fast transmitter is not missed.
                if (w_at_res) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = 3'd0;
                    if (w_vote) begin
                        w_data_nxt = r_shift;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 16'd0;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: bit counter, bit index, shift register, divisor
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_div_q <= c_DIV_9600;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_div_q <= w_div_nxt;
        end
    end

    // Registered outputs: received byte and the two completion strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_data   <= w_data_nxt;
            r_rx_done   <= w_done_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx. Frames are built from bytes and
//            baud rates at the bit level; expected strobe kind, data and
//            arrival cycle are queued when a frame starts and checked by an
//            independent monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       rxd      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .baud_set  (baud_set),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    exp_t       sb[$];
    longint     cyc      = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    logic [7:0] exp_data = 8'h00;

    // 50 MHz clock and a free-running posedge counter
    initial forever #10 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Bit period in clocks from the nominal baud rate
    function automatic int bit_period(input int b);
        int rate;
        case (b)
            1:       rate = 19200;
            2:       rate = 38400;
            3:       rate = 57600;
            4:       rate = 115200;
            default: rate = 9600;
        endcase
        return 50_000_000 / rate;
    endfunction

    // Monitor: pops the scoreboard on every strobe, otherwise checks hold
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            exp_data = 8'h00;
        end else if (rx_done || frame_err) begin
            check("strobe_exclusive", rx_done && frame_err, 0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b rx_data=%02h, expected none (cycle %0d)",
                         rx_done, frame_err, rx_data, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_is_frame_err", frame_err, e.ferr);
                check("strobe_cycle", cyc, e.cyc);
                if (!e.ferr) begin
                    check("rx_data", rx_data, e.data);
                    exp_data = e.data;
                end else begin
                    check("rx_data_kept", rx_data, exp_data);
                end
            end
        end else begin
            check("rx_data_stable", rx_data, exp_data);
        end
    end

    // Drive one 8N1 frame; called at a negedge. gbit>=0 flips the line for
    // one clock so that the receiver sees it exactly at mid-bit sample H.
    task automatic send_frame(input logic [7:0] b, input int baud, input logic stop_v,
                              input int gbit, input bit scramble, input bit expect_it);
        int         p;
        int         h;
        longint     n;
        logic [9:0] fr;
        exp_t       e;
        p        = bit_period(baud);
        h        = (p - 1) >> 1;
        baud_set = 3'(baud);
        fr       = {stop_v, b, 1'b0};
        n        = cyc;
        if (expect_it) begin
            e.ferr = !stop_v;
            e.data = b;
            e.cyc  = n + 3 + 9 * p + h + 2;
            sb.push_back(e);
        end
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < p; k++) begin
                if (gbit >= 0 && j == gbit + 1 && k == h + 1)
                    rxd = ~fr[j];
                else
                    rxd = fr[j];
                if (scramble && j == 0 && k == 5)
                    baud_set = 3'($urandom_range(0, 7));
                @(negedge clk);
            end
        end
        rxd = 1'b1;
    endtask

    // Short low pulse: receiver must abandon the start bit at mid-bit
    task automatic false_start(input int baud);
        int     p;
        int     h;
        longint n;
        p        = bit_period(baud);
        h        = (p - 1) >> 1;
        baud_set = 3'(baud);
        n        = cyc;
        for (int k = 0; k < h + 8; k++) begin
            rxd = (k < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (cyc - n == 2)     check("busy_before_start", rx_busy, 0);
            if (cyc - n == 3)     check("busy_in_start", rx_busy, 1);
            if (cyc - n == h + 4) check("busy_before_vote", rx_busy, 1);
            if (cyc - n == h + 5) check("busy_after_vote", rx_busy, 0);
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("pending_strobes", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_outputs_zero();
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
    endtask

    // Runaway guard
    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [7:0] loop_bytes [4];
        loop_bytes[0] = 8'h55;
        loop_bytes[1] = 8'h00;
        loop_bytes[2] = 8'hFF;
        loop_bytes[3] = 8'hA5;

        reset = 1'b0;
        idle(3);
        check_outputs_zero();
        reset = 1'b1;
        idle(5);

        // Loopback at 115200
        for (int i = 0; i < 4; i++) begin
            send_frame(loop_bytes[i], 4, 1'b1, -1, 1'b0, 1'b1);
            idle(10);
        end
        drain();

        // Framing error: rx_data must keep 0xA5
        send_frame(8'h3C, 4, 1'b0, -1, 1'b0, 1'b1);
        idle(10);
        drain();

        // Baud sweep: full frame at 57600, divisor timing via false starts
        send_frame(8'h3C, 3, 1'b1, -1, 1'b0, 1'b1);
        idle(10);
        drain();
        false_start(4);
        idle(10);
        false_start(2);
        idle(10);
        false_start(1);
        idle(10);
        false_start(0);
        idle(10);
        false_start(7);
        idle(10);
        drain();

        // Back-to-back frames with no idle gap
        send_frame(8'h12, 4, 1'b1, -1, 1'b0, 1'b1);
        send_frame(8'h34, 4, 1'b1, -1, 1'b0, 1'b1);
        idle(10);
        drain();

        // Single-clock glitch at mid-bit inside a data bit
        send_frame(8'h5A, 4, 1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b1);
        idle(10);
        drain();

        // Reset during bit 3 of 0xC3; then 0x81 must be received cleanly
        fork
            send_frame(8'hC3, 4, 1'b1, -1, 1'b0, 1'b0);
            begin
                repeat (4 * 434 + 200) @(negedge clk);
                check("busy_mid_frame", rx_busy, 1);
                #2 reset = 1'b0;
                #1 check_outputs_zero();
            end
        join
        idle(5);
        reset = 1'b1;
        idle(10);
        send_frame(8'h81, 4, 1'b1, -1, 1'b0, 1'b1);
        idle(10);
        drain();

        // Random bytes, random glitch bit, occasional bad stop bit, and
        // baud_set scrambled after the divisor has been latched
        for (int r = 0; r < 2; r++) begin
            send_frame(8'($urandom), 4, ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 8)) - 1, 1'b1, 1'b1);
            idle(10);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver paired with the team's 8N1 UART transmitter. It recovers 8-bit bytes from the `rxd` line at one of five baud rates on a 50 MHz clock, using the same `baud_set` encoding and divisor table as the transmitter. Each bit is sampled three times near mid-bit and resolved by majority vote. The block raises a one-cycle strobe for each good byte and a separate strobe for each framing error; it sits between the board serial pin and the downstream frame parser.

## Interface
- Parameters: none. The divisor table is fixed.
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-low
- `baud_set`  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5–7=9600
- `rxd`  in  1  serial input, asynchronous to `clk`, idle high
- `rx_data`  out  8  last correctly received byte
- `rx_done`  out  1  one-cycle pulse: `rx_data` was just updated
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0
- `rx_busy`  out  1  high while the FSM is outside IDLE

## Operation
- Divisor `bps_DR`: 5207, 2603, 1301, 867, 433 for settings 0–4; 5207 for 5–7.
  - Bit period P = `bps_DR` + 1 clocks, matching the transmitter.
  - Half point H = `bps_DR` >> 1.
- Divisor latch: `bps_DR` is captured into `div_q` on entry to START and held for the whole frame. `baud_set` changes mid-frame have no effect until the next frame.
- Input sync: `rxd` passes through a 2-flop synchronizer (both flops reset to 1) into `rx_s`. A third flop `rx_p` holds the previous `rx_s`.
- Start detect: a falling edge is `rx_p`=1 and `rx_s`=0.
- Counters:
  - `cnt`: 16-bit, counts 0..`div_q`, returns to 0 at each bit boundary.
  - `idx`: 3-bit data-bit index.
- Majority vote: `rx_s` is sampled at `cnt` = H-1, H and H+1. The bit value is the majority of the three, resolved at `cnt` = H+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `cnt`=0, `idx`=0. On a falling edge, go to START and latch `div_q`.
  - START: `cnt` increments. If the resolved bit is 1, this is a false start: go to IDLE with no strobe. Otherwise, at `cnt`=`div_q`, go to DATA with `cnt`=0 and `idx`=0.
  - DATA: the resolved bit is written to `shift[idx]` (LSB first). At `cnt`=`div_q`:
    - if `idx`=7, go to STOP;
    - otherwise increment `idx`.
    - In both cases `cnt` returns to 0.
  - STOP: when the bit resolves at `cnt`=H+1, go to IDLE in the same edge.
    - Bit = 1: `rx_data` <= `shift`, `rx_done` pulses.
    - Bit = 0: `frame_err` pulses; `rx_data` is unchanged.
  - Illegal state: go to IDLE.
- Early return: leaving STOP at mid-bit gives half a bit of slack, so back-to-back frames from a slightly fast transmitter are still caught.
- After a framing error the line may still be low. A new frame is accepted only after `rx_s` returns high and then falls again.
- `rx_busy` = (state != IDLE).

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_done`=0, `frame_err`=0, `rx_busy`=0;
  - state=IDLE; `cnt`=0, `idx`=0, `shift`=0;
  - synchronizer flops and `rx_p`=1; `div_q`=5207.
- Input latency: a falling edge on `rxd` is detected 2–3 clocks later. START is entered on the following edge, called e0.
- `rx_done` and `frame_err` are registered. They are high for exactly the one cycle following edge e0+9P+H+2, and never both high.
- `rx_data` changes only on the edge that raises `rx_done`, and is stable until the next `rx_done`.
- Reset asserted mid-frame: everything returns immediately to reset values. No strobe is produced, and the partial byte is discarded.
- Sample tolerance: majority voting rejects a single-clock glitch within the H-1..H+1 window.

## Test plan
- Loopback through the transmitter, `baud_set`=4: send 0x55, then 0x00, 0xFF, 0xA5. Expect one `rx_done` per byte, `rx_data` equal to the sent byte, `frame_err`=0, and `rx_done` at e0+9·434+216+2.
- Sweep `baud_set` 0–3 and 7 (7 = 9600) with byte 0x3C from the transmitter. Expect `rx_data`=0x3C each time and bit periods of 5208/2604/1302/868/5208 clocks.
- Glitch start, `baud_set`=4: hold `rxd` low for 100 clocks, then high. Expect return to IDLE by mid start bit, no `rx_done`, no `frame_err`, and `rx_busy` low again by e0+219.
- Framing error, `baud_set`=4: byte 0x3C with the stop bit driven 0. Expect a single `frame_err` pulse, `rx_data` kept at the previous byte, and no `rx_done`.
- Back-to-back, `baud_set`=4: transmitter with `send_en` held high for two frames, 0x12 then 0x34. Expect two `rx_done` pulses about 10 bit periods apart, with `rx_data` 0x12 then 0x34. Separately, inject a 1-clock glitch at `cnt`=H inside a data bit; the byte must still be correct.
- Reset mid-frame: assert `reset` during bit 3 of 0xC3. Expect all outputs 0 immediately. Then receive the next frame, 0x81, correctly with `rx_done`=1 and `rx_data`=0x81.
